dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-ported data memory (`WORD`-wide, 32 words, byte-addressed with word index = address/8). Shares the memory between the CPU load/store stage (port 0) and the debug/loader port (port 1), issuing one MemRead/MemWrite pulse per transaction and returning data with a one-cycle acknowledge. Sits between the MEM pipeline stage and data_mem; data_mem's read_clk and write_clk are both tied to this block's clk.

---
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter and access sequencer for the single-ported data memory.
//   Port 0 is the CPU load/store stage and port 1 is the debug/loader port.
//   The block issues one mem_read or mem_write pulse per transaction and
//   returns completion as a one-cycle ack, plus err for rejected accesses.
//   Every transaction runs IDLE -> [ISSUE -> [WAIT]] -> RESP -> IDLE.
//
//   Build option DMEM_ARB_RR_EN:
//     defined   - round-robin between simultaneous requesters.
//     undefined - fixed priority, port 0 wins.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   reqN/weN/addrN/wdataN  request side, held stable until ackN
//   ackN/errN              one-cycle completion; errN = rejected, no access
//   rdataN                 last successful read data on port N
//   mem_read/mem_write     one-cycle strobes to data_mem (ISSUE only)
//   mem_addr/mem_wdata     last latched request (byte address, unmodified)
//   mem_rdata              registered read data from data_mem (sampled in WAIT)
//   busy                   high whenever the sequencer is not idle

// Per-port read-data holding register. It is loaded only by a successful
// read on this port, so writes and errors leave it untouched.
module dmem_arb_port #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end
endmodule

module dmem_arbiter #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int NUM_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // First illegal byte address.
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_WORDS * 8);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                 state, state_nx;
  req_t   [1:0]           rq;
  req_t                   cur_q;
  logic                   port_q, err_q;
  logic                   gnt, take, sel_bad, cap;
  logic   [1:0]           req_v, ack_v, err_v;
  logic   [1:0][DATA_W-1:0] rdata_v;

  assign req_v = {req1, req0};
  assign rq[0] = '{we: we0, addr: addr0, wdata: wdata0};
  assign rq[1] = '{we: we1, addr: addr1, wdata: wdata1};

  // A grant is only taken while idle; requests arriving in any other state
  // simply wait at the req level.
  assign take    = (state == IDLE) && (|req_v);
  assign sel_bad = (rq[gnt].addr[2:0] != 3'b000) || (rq[gnt].addr >= ADDR_LIMIT);

`ifdef DMEM_ARB_RR_EN
  // last_q = port granted most recently; reset as if port 1 had just won so
  // port 0 takes the first contended grant. Error grants also advance it.
  logic last_q;

  assign gnt = (&req_v) ? ~last_q : req_v[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= 1'b1;
    else if (take) last_q <= gnt;
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not requesting.
  assign gnt = ~req_v[0];
`endif

  // Transaction latch. mem_addr/mem_wdata are driven straight from here so
  // they keep the last latched values between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      port_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (take) begin
      cur_q  <= rq[gnt];
      port_q <= gnt;
      err_q  <= sel_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE:  if (|req_v) state_nx = sel_bad ? RESP : ISSUE;
      ISSUE: begin
        mem_read  = ~cur_q.we;
        mem_write =  cur_q.we;
        state_nx  = cur_q.we ? RESP : WAIT;
      end
      // data_mem registered the read at the end of ISSUE; grab it now.
      WAIT:  begin
        cap      = 1'b1;
        state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    logic hit;
    assign hit      = (port_q == 1'(i));
    assign ack_v[i] = (state == RESP) && hit;
    assign err_v[i] = (state == RESP) && hit && err_q;

    dmem_arb_port #(.DATA_W(DATA_W)) u_port (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cap && hit),
      .d     (mem_rdata),
      .q     (rdata_v[i])
    );
  end

  assign ack0      = ack_v[0];
  assign ack1      = ack_v[1];
  assign err0      = err_v[0];
  assign err1      = err_v[1];
  assign rdata0    = rdata_v[0];
  assign rdata1    = rdata_v[1];
  assign mem_addr  = cur_q.addr;
  assign mem_wdata = cur_q.wdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized two-port traffic, all checked every cycle against a
// transaction-level schedule model and a reference memory.
module tb_dmem_arbiter;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1, mem_read, mem_write, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Stand-in for data_mem: registered read, synchronous write.
  bit [DW-1:0] dm [NW];
  bit [DW-1:0] dm_rd;
  always @(posedge clk) begin
    if (mem_write) dm[mem_addr[7:3]] <= mem_wdata;
    if (mem_read)  dm_rd <= dm[mem_addr[7:3]];
  end
  assign mem_rdata = dm_rd;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    chk(n, {63'd0, a}, {63'd0, e});
  endtask

  task automatic chki(input string n, input int a, input int e);
    chk(n, 64'(a), 64'(e));
  endtask

  // ---------------- reference model ----------------
  // Per-period expected outputs. A granted transaction expands into the
  // list of output periods it must produce: error = 1 period, write = 2,
  // read = 3; the model is idle again only after that list drains.
  typedef struct {
    bit            busy, rd, wr, ack0, ack1, err0, err1, set_rd, port;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdv;
  } exp_t;

  exp_t          sched[$];
  exp_t          cur;
  bit   [DW-1:0] ref_mem [NW];
  logic [DW-1:0] exp_rd [2];
  bit            last;

  task automatic plan();
    bit            w, wr, bad;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t          e;
`ifdef DMEM_ARB_RR_EN
    if (req0 && req1) w = ~last;
    else              w = req1;
    last = w;
`else
    w = req0 ? 1'b0 : 1'b1;
`endif
    wr  = w ? we1 : we0;
    a   = w ? addr1 : addr0;
    d   = w ? wdata1 : wdata0;
    bad = (a[2:0] != 3'b000) || (a >= 64'(NW * 8));
    e = '{default: '0};
    e.busy = 1'b1;
    e.port = w;
    if (!bad) begin
      e.rd = !wr; e.wr = wr; e.addr = a; e.wdata = d;
      sched.push_back(e);
      e.rd = 1'b0; e.wr = 1'b0;
      if (!wr) sched.push_back(e);
    end
    e.ack0 = !w;
    e.ack1 = w;
    e.err0 = bad && !w;
    e.err1 = bad && w;
    if (!bad && !wr) begin
      e.set_rd = 1'b1;
      e.rdv    = ref_mem[a[7:3]];
    end
    if (!bad && wr) ref_mem[a[7:3]] = d;
    sched.push_back(e);
  endtask

  initial begin
    cur = '{default: '0};
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sched.delete();
        cur = '{default: '0};
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        last = 1'b1;
      end else begin
        if (!cur.busy && (req0 || req1)) plan();
        if (sched.size() > 0) cur = sched.pop_front();
        else                  cur = '{default: '0};
        if (cur.set_rd) exp_rd[cur.port] = cur.rdv;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    #3;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_err0", err0, 1'b0);
        chk1("rst_err1", err1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk("rst_rdata0", rdata0, '0);
        chk("rst_rdata1", rdata1, '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
      end else begin
        chk1("busy", busy, cur.busy);
        chk1("mem_read", mem_read, cur.rd);
        chk1("mem_write", mem_write, cur.wr);
        chk1("ack0", ack0, cur.ack0);
        chk1("ack1", ack1, cur.ack1);
        chk1("err0", err0, cur.err0);
        chk1("err1", err1, cur.err1);
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
        if (cur.rd || cur.wr) chk("mem_addr", mem_addr, cur.addr);
        if (cur.wr)           chk("mem_wdata", mem_wdata, cur.wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  // One transaction on port p; lat counts clock edges from the sampling edge
  // up to the period in which ack is visible.
  task automatic do_txn(input bit p, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output bit er);
    @(posedge clk); #2;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    lat = 0;
    er  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (p ? ack1 : ack0) begin
        er = p ? err1 : err0;
        break;
      end
    end
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  task automatic rand_port(input bit p);
    bit            r, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            k, idx;
    r   = ($urandom_range(0, 3) != 0);
    w   = $urandom_range(0, 1) == 1;
    k   = $urandom_range(0, 9);
    idx = $urandom_range(0, 7);
    if (k < 7)       a = 64'(idx * 8);
    else if (k == 7) a = 64'(idx * 8 + $urandom_range(1, 7));
    else if (k == 8) a = 64'(256 + idx * 8);
    else             a = 64'hFFFF_FFFF_FFFF_FFF8;
    d = {$urandom, $urandom};
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  initial begin
    int lat;
    bit er;
    int seq[$];

    // Reset held with both ports requesting reads of 0x00 / 0x08.
    #1 rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'h08;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_ack0", ack0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("grant_after_reset", busy, 1'b1);
    for (int i = 0; i < 40 && seq.size() < 4; i++) begin
      @(negedge clk);
      if (ack0) seq.push_back(0);
      if (ack1) seq.push_back(1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chki("contended_ack_count", seq.size(), 4);
    for (int i = 0; i < seq.size() && i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      chki("contended_ack_order", seq[i], i % 2);
`else
      chki("contended_ack_order", seq[i], 0);
`endif
    end

    // Write then read back on port 0.
    do_txn(1'b0, 1'b1, 64'h10, 64'hDEADBEEF, lat, er);
    chki("wr_latency", lat, 2);
    chk1("wr_err", er, 1'b0);
    do_txn(1'b0, 1'b0, 64'h10, 64'h0, lat, er);
    chki("rd_latency", lat, 3);
    chk1("rd_err", er, 1'b0);
    chk("rd_data0", rdata0, 64'hDEADBEEF);

    // Port 1 write/read, then a misaligned read that must not touch rdata1.
    do_txn(1'b1, 1'b1, 64'h08, 64'h1111_2222_3333_4444, lat, er);
    chki("wr1_latency", lat, 2);
    do_txn(1'b1, 1'b0, 64'h08, 64'h0, lat, er);
    chki("rd1_latency", lat, 3);
    chk("rd_data1", rdata1, 64'h1111_2222_3333_4444);
    do_txn(1'b1, 1'b0, 64'h0C, 64'h0, lat, er);
    chki("misaligned_latency", lat, 1);
    chk1("misaligned_err1", er, 1'b1);
    chk("misaligned_rdata1", rdata1, 64'h1111_2222_3333_4444);

    // Out-of-range write.
    do_txn(1'b0, 1'b1, 64'h100, 64'h55, lat, er);
    chki("oob_latency", lat, 1);
    chk1("oob_err0", er, 1'b1);

    // Reset during WAIT of a port-0 read, then reissue.
    @(posedge clk); #2;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    req0  = 1'b0;
    @(negedge clk);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ack0", ack0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_txn(1'b0, 1'b0, 64'h10, 64'h0, lat, er);
    chki("reissue_latency", lat, 3);
    chk("reissue_data0", rdata0, 64'hDEADBEEF);

    // Random two-port traffic; each port holds its request until acked.
    for (int c = 0; c < 1500; c++) begin
      bit a0, a1;
      @(negedge clk);
      a0 = ack0;
      a1 = ack1;
      @(posedge clk); #2;
      if (!req0 || a0) rand_port(1'b0);
      if (!req1 || a1) rand_port(1'b1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
